unidade_busca: RTL



---
 rtl/busca_pkg.sv | 19 +
 rtl/unidade_busca_if.sv | 30 +++
 rtl/fila_busca.sv | 65 ++++++
 rtl/unidade_busca.sv | 132 +++++++++++++
 4 files changed

// File: rtl/busca_pkg.sv
// Shared types and constants for the instruction-fetch unit.
// Latency: none (declarations only).
// Backpressure: not applicable.
package busca_pkg;

  // Fetch FSM: nothing outstanding, response pending, pending response is stale
  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    ESPERA   = 2'd1,
    DESCARTE = 2'd2
  } estado_busca_t;

  localparam int INCR_PC = 4;

  // Widths of the saturating statistics counters
  localparam int LARG_BOLHAS    = 32;
  localparam int LARG_DESCARTES = 16;

endpackage

// File: rtl/unidade_busca_if.sv
// Fetch-unit bus: memory request/response, redirect, and decode-side queue head.
// Latency: none (wires only).
// Backpressure: mem_pronto throttles requests, parada holds the queue head.
interface unidade_busca_if #(
  parameter int LARGURA = 32
);
  logic               mem_req;
  logic [LARGURA-1:0] mem_end;
  logic               mem_pronto;
  logic               mem_valido;
  logic [LARGURA-1:0] mem_dado;
  logic               desvio;
  logic [LARGURA-1:0] endereco_salto;
  logic               parada;
  logic               inst_valido;
  logic [LARGURA-1:0] inst;
  logic [LARGURA-1:0] inst_pc;

  // Fetch unit side
  modport master (
    output mem_req, mem_end, inst_valido, inst, inst_pc,
    input  mem_pronto, mem_valido, mem_dado, desvio, endereco_salto, parada
  );

  // Memory / pipeline side
  modport slave (
    input  mem_req, mem_end, inst_valido, inst, inst_pc,
    output mem_pronto, mem_valido, mem_dado, desvio, endereco_salto, parada
  );
endinterface

// File: rtl/fila_busca.sv
// Circular prefetch queue of {pc, instruction} entries; flush has priority.
// Latency: a push is visible at the head the cycle after the write edge.
// Backpressure: push ignored when full, pop ignored when empty.
module fila_busca #(
  parameter  int LARGURA      = 32,
  parameter  int PROFUNDIDADE = 4,
  localparam int PW           = $clog2(PROFUNDIDADE),
  localparam int CW           = PW + 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [LARGURA-1:0] entra_pc,
  input  logic [LARGURA-1:0] entra_inst,
  output logic [LARGURA-1:0] cabeca_pc,
  output logic [LARGURA-1:0] cabeca_inst,
  output logic [CW-1:0]      cont
);

  logic [LARGURA-1:0] mem_pc   [PROFUNDIDADE];
  logic [LARGURA-1:0] mem_inst [PROFUNDIDADE];
  logic [PW-1:0]      ptr_esc;
  logic [PW-1:0]      ptr_lei;
  logic               push_ok;
  logic               pop_ok;

  assign push_ok     = push && (cont != CW'(PROFUNDIDADE));
  assign pop_ok      = pop && (cont != '0);
  assign cabeca_pc   = mem_pc[ptr_lei];
  assign cabeca_inst = mem_inst[ptr_lei];

  // Pointers wrap naturally because the depth is a power of two
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_esc <= '0;
      ptr_lei <= '0;
      cont    <= '0;
      for (int i = 0; i < PROFUNDIDADE; i++) begin
        mem_pc[i]   <= '0;
        mem_inst[i] <= '0;
      end
    end else if (flush) begin
      ptr_esc <= '0;
      ptr_lei <= '0;
      cont    <= '0;
    end else begin
      if (push_ok) begin
        mem_pc[ptr_esc]   <= entra_pc;
        mem_inst[ptr_esc] <= entra_inst;
        ptr_esc           <= ptr_esc + 1'b1;
      end
      if (pop_ok) begin
        ptr_lei <= ptr_lei + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   cont <= cont + 1'b1;
        2'b01:   cont <= cont - 1'b1;
        default: cont <= cont;
      endcase
    end
  end

endmodule

// File: rtl/unidade_busca.sv
// Instruction fetch: owns the PC, one outstanding memory request, prefetch queue to IF/ID.
// Latency: accept at edge N, response in the following cycle, queue head valid after edge N+1 of response.
// Backpressure: parada holds the head; requests stop once the queue cannot take the reply. Option: BUSCA_STATS_EN.
module unidade_busca
  import busca_pkg::*;
#(
  parameter int                 LARGURA      = 32,
  parameter int                 PROFUNDIDADE = 4,
  parameter logic [LARGURA-1:0] PC_INICIAL   = '0
) (
  input  logic                      clock,
  input  logic                      reset_n,
  unidade_busca_if.master           bus
`ifdef BUSCA_STATS_EN
  ,
  output logic [LARG_BOLHAS-1:0]    cont_bolhas,
  output logic [LARG_DESCARTES-1:0] cont_descartes
`endif
);

  localparam int                CW    = $clog2(PROFUNDIDADE) + 1;
  localparam logic [CW-1:0]     CHEIO = CW'(PROFUNDIDADE);
  localparam logic [CW-1:0]     QUASE = CW'(PROFUNDIDADE - 1);

  estado_busca_t      estado, prox_estado;
  logic [LARGURA-1:0] pc_busca;
  logic [LARGURA-1:0] end_pend;
  logic [LARGURA-1:0] alvo;
  logic [CW-1:0]      cont;
  logic               req_int;
  logic               aceite;
  logic               push;
  logic               pop;

  // Low two bits of the target are masked off rather than sliced away
  assign alvo = bus.endereco_salto & ~LARGURA'(3);

  assign bus.mem_req     = req_int && reset_n;
  assign bus.mem_end     = pc_busca;
  assign bus.inst_valido = (cont != '0);
  assign aceite          = req_int && bus.mem_pronto;
  assign push            = (estado == ESPERA) && bus.mem_valido && !bus.desvio;
  assign pop             = bus.inst_valido && !bus.parada && !bus.desvio;

  // Request issue and next state; a redirect blocks issue and may leave a stale reply in flight
  always_comb begin
    req_int     = 1'b0;
    prox_estado = estado;
    case (estado)
      OCIOSO:   req_int = (cont < CHEIO);
      ESPERA:   req_int = bus.mem_valido && (cont < QUASE);
      default:  req_int = 1'b0;
    endcase
    if (bus.desvio) begin
      req_int = 1'b0;
    end
    if (bus.desvio) begin
      if ((estado == ESPERA || estado == DESCARTE) && !bus.mem_valido) begin
        prox_estado = DESCARTE;
      end else begin
        prox_estado = OCIOSO;
      end
    end else begin
      case (estado)
        OCIOSO:   if (aceite) prox_estado = ESPERA;
        ESPERA:   if (bus.mem_valido) prox_estado = aceite ? ESPERA : OCIOSO;
        DESCARTE: if (bus.mem_valido) prox_estado = OCIOSO;
        default:  prox_estado = OCIOSO;
      endcase
    end
  end

  // State, fetch PC and address of the outstanding request
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado   <= OCIOSO;
      pc_busca <= PC_INICIAL;
      end_pend <= PC_INICIAL;
    end else begin
      estado <= prox_estado;
      if (bus.desvio) begin
        pc_busca <= alvo;
      end else if (aceite) begin
        pc_busca <= pc_busca + LARGURA'(INCR_PC);
      end
      if (aceite) begin
        end_pend <= pc_busca;
      end
    end
  end

  fila_busca #(
    .LARGURA      (LARGURA),
    .PROFUNDIDADE (PROFUNDIDADE)
  ) u_fila (
    .clock       (clock),
    .reset_n     (reset_n),
    .push        (push),
    .pop         (pop),
    .flush       (bus.desvio),
    .entra_pc    (end_pend),
    .entra_inst  (bus.mem_dado),
    .cabeca_pc   (bus.inst_pc),
    .cabeca_inst (bus.inst),
    .cont        (cont)
  );

`ifdef BUSCA_STATS_EN
  logic bolha;
  logic descarte;

  assign bolha    = !bus.inst_valido && !bus.parada;
  assign descarte = bus.mem_valido &&
                    ((estado == DESCARTE) || (estado == ESPERA && bus.desvio));

  // Saturating bubble and dropped-response counters
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cont_bolhas    <= '0;
      cont_descartes <= '0;
    end else begin
      if (bolha && cont_bolhas != '1) begin
        cont_bolhas <= cont_bolhas + 1'b1;
      end
      if (descarte && cont_descartes != '1) begin
        cont_descartes <= cont_descartes + 1'b1;
      end
    end
  end
`endif

endmodule
